multicycle_control_unit: RTL and testbench

//  Multi-cycle successor to the single-cycle RV32I decoder. FSM-sequenced control for a shared-ALU datapath.

---
 rtl/multicycle_control_unit_pkg.sv | 91 +++++++++
 rtl/multicycle_control_unit_branch_cond.sv | 28 ++
 rtl/multicycle_control_unit.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I(M) control unit:
// FSM states, ALU codes, opcodes and mux selects.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_MULDIV,
      S_WB,
      S_TRAP
   } state_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_SLT  = 4'h5,
      ALU_SLL  = 4'h6,
      ALU_SRL  = 4'h7,
      ALU_SRA  = 4'h8,
      ALU_MUL  = 4'h9,
      ALU_MULH = 4'hA,
      ALU_DIV  = 4'hB,
      ALU_REM  = 4'hC,
      ALU_SLTU = 4'hD
   } alu_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JALR   = 2'b10;
   localparam logic [1:0] PC_TRAP   = 2'b11;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;
   localparam logic [1:0] RES_IMM = 2'b11;

   // SUB exists only for register-register ops; ADDI has no subtract form
   function automatic alu_e base_alu(input logic [2:0] f3,
                                     input logic alt,
                                     input logic is_reg);
      unique case (f3)
         3'b000:  base_alu = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         3'b001:  base_alu = ALU_SLL;
         3'b010:  base_alu = ALU_SLT;
         3'b011:  base_alu = ALU_SLTU;
         3'b100:  base_alu = ALU_XOR;
         3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
         3'b110:  base_alu = ALU_OR;
         default: base_alu = ALU_AND;
      endcase
   endfunction

   function automatic alu_e m_alu(input logic [2:0] f3);
      unique case (f3)
         3'b000:  m_alu = ALU_MUL;
         3'b001,
         3'b010,
         3'b011:  m_alu = ALU_MULH;
         3'b100,
         3'b101:  m_alu = ALU_DIV;
         default: m_alu = ALU_REM;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_branch_cond.sv
// Branch resolution from ALU compare flags; flags reserved func3
// encodings so the FSM can trap on them.
module multicycle_control_unit_branch_cond
   import multicycle_control_unit_pkg::*;
(
   input  logic [2:0] func3,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       alu_ltu,
   output logic       taken,
   output logic       invalid
);

   always_comb begin
      taken   = 1'b0;
      invalid = 1'b0;
      unique case (func3)
         BR_EQ:   taken = alu_zero;
         BR_NE:   taken = !alu_zero;
         BR_LT:   taken = alu_lt;
         BR_GE:   taken = !alu_lt;
         BR_LTU:  taken = alu_ltu;
         BR_GEU:  taken = !alu_ltu;
         default: invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// FSM-sequenced control for a shared-ALU RV32I(M) datapath with
// handshaked instruction/data memories and multi-cycle MUL/DIV.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter bit ENABLE_M   = 1'b1,
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       alu_ltu,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       alu_src,
   output logic       alu_a_pc,
   output logic [3:0] alu_control,
   output logic [1:0] result_src,
   output logic       busy,
   output logic       illegal
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic is_r, is_rb, is_m, is_imm, is_load, is_store;
   logic is_br, is_jal, is_jalr, is_lui, is_auipc;
   logic f7_ok, legal;
   logic br_taken, br_invalid;
   alu_e op_alu;

   multicycle_control_unit_branch_cond u_br (
      .func3    (func3),
      .alu_zero (alu_zero),
      .alu_lt   (alu_lt),
      .alu_ltu  (alu_ltu),
      .taken    (br_taken),
      .invalid  (br_invalid)
   );

   always_comb begin
      is_r     = opcode == OP_R;
      is_imm   = opcode == OP_IMM;
      is_load  = opcode == OP_LOAD;
      is_store = opcode == OP_STORE;
      is_br    = opcode == OP_BRANCH;
      is_jal   = opcode == OP_JAL;
      is_jalr  = opcode == OP_JALR;
      is_lui   = opcode == OP_LUI;
      is_auipc = opcode == OP_AUIPC;
      is_m     = is_r && func7 == F7_M;
      is_rb    = is_r && !is_m;
      f7_ok    = func7 == F7_BASE || func7 == F7_ALT ||
                 (func7 == F7_M && ENABLE_M);
      legal    = (is_r && f7_ok) || is_imm || is_load ||
                 is_store || is_br || is_jal || is_jalr ||
                 is_lui || is_auipc;
      op_alu = ALU_ADD;
      unique case (1'b1)
         is_m:    op_alu = m_alu(func3);
         is_rb:   op_alu = base_alu(func3, func7[5], 1'b1);
         is_imm:  op_alu = base_alu(func3, func7[5], 1'b0);
         is_br:   op_alu = ALU_SUB;
         default: op_alu = ALU_ADD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_PLUS4;
      reg_write   = 1'b0;
      alu_src     = 1'b0;
      alu_a_pc    = 1'b0;
      alu_control = ALU_ADD;
      result_src  = RES_ALU;
      busy        = state_q != S_FETCH;
      illegal     = 1'b0;
      // ALU controls stay valid until the result is consumed
      if (state_q inside {S_EXEC, S_MEM, S_MULDIV, S_WB}) begin
         alu_control = op_alu;
         alu_src     = !(is_r || is_br);
         alu_a_pc    = is_auipc;
      end
      unique case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready && !rst) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!legal) begin
               state_d = S_TRAP;
            end else if (is_m) begin
               state_d = S_MULDIV;
               cnt_d   = func3[2] ? DIV_LOAD : MUL_LOAD;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_br) begin
               if (br_invalid) begin
                  state_d = S_TRAP;
               end else begin
                  pc_write = 1'b1;
                  pc_src   = br_taken ? PC_BRANCH : PC_PLUS4;
                  state_d  = S_FETCH;
               end
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            mem_write = is_store;
            if (dmem_ready) begin
               pc_write = is_store;
               state_d  = is_store ? S_FETCH : S_WB;
            end
         end
         S_MULDIV: begin
            if (cnt_q == '0) state_d = S_WB;
            else cnt_d = cnt_q - CNT_W'(1);
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
            unique case (1'b1)
               is_load:          result_src = RES_MEM;
               is_jal || is_jalr: result_src = RES_PC4;
               is_lui:           result_src = RES_IMM;
               default:          result_src = RES_ALU;
            endcase
            if (is_jal) pc_src = PC_BRANCH;
            else if (is_jalr) pc_src = PC_JALR;
         end
         S_TRAP: begin
            illegal  = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_TRAP;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed vector bench for multicycle_control_unit: per-instruction
// cycle counts, strobes and selects, plus memory-stall and reset cases.
module tb_multicycle_control_unit;

   localparam logic [6:0] R   = 7'b0110011;
   localparam logic [6:0] I   = 7'b0010011;
   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] JR  = 7'b1100111;
   localparam logic [6:0] LU  = 7'b0110111;
   localparam logic [6:0] AU  = 7'b0010111;
   localparam logic [6:0] SYS = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode, func7;
   logic [2:0] func3;
   logic       imem_ready, dmem_ready;
   logic       alu_zero, alu_lt, alu_ltu;

   logic       imem_req, dmem_req, mem_write, ir_write, pc_write;
   logic [1:0] pc_src, result_src;
   logic       reg_write, alu_src, alu_a_pc, busy, illegal;
   logic [3:0] alu_control;

   logic       n_imem_req, n_dmem_req, n_mem_write, n_ir_write;
   logic       n_pc_write, n_reg_write, n_alu_src, n_alu_a_pc;
   logic       n_busy, n_illegal;
   logic [1:0] n_pc_src, n_result_src;
   logic [3:0] n_alu_control;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control_unit u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
      .func7(func7), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero),
      .alu_lt(alu_lt), .alu_ltu(alu_ltu), .imem_req(imem_req),
      .dmem_req(dmem_req), .mem_write(mem_write),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .alu_src(alu_src),
      .alu_a_pc(alu_a_pc), .alu_control(alu_control),
      .result_src(result_src), .busy(busy), .illegal(illegal)
   );

   multicycle_control_unit #(.ENABLE_M(1'b0)) u_nom (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
      .func7(func7), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .alu_zero(alu_zero),
      .alu_lt(alu_lt), .alu_ltu(alu_ltu), .imem_req(n_imem_req),
      .dmem_req(n_dmem_req), .mem_write(n_mem_write),
      .ir_write(n_ir_write), .pc_write(n_pc_write),
      .pc_src(n_pc_src), .reg_write(n_reg_write),
      .alu_src(n_alu_src), .alu_a_pc(n_alu_a_pc),
      .alu_control(n_alu_control), .result_src(n_result_src),
      .busy(n_busy), .illegal(n_illegal)
   );

   typedef struct {
      string      nm;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       z, lt, ltu;
      int         cyc, rw, pw, ill, pcs, rs, alu;
   } vec_t;

   typedef struct {
      int cyc, rw, pw, ill, pcs, rs, alu, memc, mw, nill, npcs, nrw;
   } obs_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic [6:0] op,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic z, input logic lt,
                               input logic ltu, input int cyc,
                               input int rw, input int pw, input int ill,
                               input int pcs, input int rs, input int alu);
      vec_t v;
      v.nm = nm; v.op = op; v.f3 = f3; v.f7 = f7;
      v.z = z; v.lt = lt; v.ltu = ltu;
      v.cyc = cyc; v.rw = rw; v.pw = pw; v.ill = ill;
      v.pcs = pcs; v.rs = rs; v.alu = alu;
      return v;
   endfunction

   // Starts just after a rising edge with both DUTs in FETCH
   task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic z,
                         input logic lt, input logic ltu,
                         input int dly, output obs_t o);
      int memc;
      o = '{default: 0};
      memc = 0;
      opcode = op; func3 = f3; func7 = f7;
      alu_zero = z; alu_lt = lt; alu_ltu = ltu;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         dmem_ready = dmem_req && (memc == dly);
         #1;
         o.cyc++;
         if (dmem_req) begin
            memc++;
            o.memc++;
            if (mem_write) o.mw++;
         end
         if (reg_write) begin o.rw++; o.rs = int'(result_src); end
         if (pc_write) begin
            o.pw++;
            o.pcs = int'(pc_src);
            o.alu = int'(alu_control);
         end
         if (illegal) o.ill++;
         if (n_illegal) o.nill++;
         if (n_pc_write) o.npcs = int'(n_pc_src);
         if (n_reg_write) o.nrw++;
         @(posedge clk);
         #1;
         imem_ready = 1'b0;
         dmem_ready = 1'b0;
         if (!busy) return;
      end
      chk("timeout", 1, 0);
   endtask

   vec_t vecs[$];
   obs_t o;

   initial begin
      vecs.push_back(mk("ADD",    R,  3'd0, 7'h00, 0,0,0, 4,1,1,0,0,0,4'h0));
      vecs.push_back(mk("SUB",    R,  3'd0, 7'h20, 0,0,0, 4,1,1,0,0,0,4'h1));
      vecs.push_back(mk("SLT",    R,  3'd2, 7'h00, 0,0,0, 4,1,1,0,0,0,4'h5));
      vecs.push_back(mk("SLTU",   R,  3'd3, 7'h00, 0,0,0, 4,1,1,0,0,0,4'hD));
      vecs.push_back(mk("SRA",    R,  3'd5, 7'h20, 0,0,0, 4,1,1,0,0,0,4'h8));
      vecs.push_back(mk("ADDI",   I,  3'd0, 7'h20, 0,0,0, 4,1,1,0,0,0,4'h0));
      vecs.push_back(mk("XORI",   I,  3'd4, 7'h00, 0,0,0, 4,1,1,0,0,0,4'h4));
      vecs.push_back(mk("SLTIU",  I,  3'd3, 7'h00, 0,0,0, 4,1,1,0,0,0,4'hD));
      vecs.push_back(mk("SRAI",   I,  3'd5, 7'h20, 0,0,0, 4,1,1,0,0,0,4'h8));
      vecs.push_back(mk("SRLI",   I,  3'd5, 7'h00, 0,0,0, 4,1,1,0,0,0,4'h7));
      vecs.push_back(mk("LW",     LD, 3'd2, 7'h00, 0,0,0, 5,1,1,0,0,1,4'h0));
      vecs.push_back(mk("SW",     ST, 3'd2, 7'h00, 0,0,0, 4,0,1,0,0,0,4'h0));
      vecs.push_back(mk("BEQ_T",  BR, 3'd0, 7'h00, 1,0,0, 3,0,1,0,1,0,4'h1));
      vecs.push_back(mk("BEQ_N",  BR, 3'd0, 7'h00, 0,0,0, 3,0,1,0,0,0,4'h1));
      vecs.push_back(mk("BNE_T",  BR, 3'd1, 7'h00, 0,0,0, 3,0,1,0,1,0,4'h1));
      vecs.push_back(mk("BLT_T",  BR, 3'd4, 7'h00, 0,1,0, 3,0,1,0,1,0,4'h1));
      vecs.push_back(mk("BGE_N",  BR, 3'd5, 7'h00, 0,1,0, 3,0,1,0,0,0,4'h1));
      vecs.push_back(mk("BLTU_T", BR, 3'd6, 7'h00, 0,0,1, 3,0,1,0,1,0,4'h1));
      vecs.push_back(mk("BGEU_T", BR, 3'd7, 7'h00, 0,0,0, 3,0,1,0,1,0,4'h1));
      vecs.push_back(mk("BR_010", BR, 3'd2, 7'h00, 0,0,0, 4,0,1,1,3,0,4'h0));
      vecs.push_back(mk("JAL",    JL, 3'd0, 7'h00, 0,0,0, 4,1,1,0,1,2,4'h0));
      vecs.push_back(mk("JALR",   JR, 3'd0, 7'h00, 0,0,0, 4,1,1,0,2,2,4'h0));
      vecs.push_back(mk("LUI",    LU, 3'd0, 7'h00, 0,0,0, 4,1,1,0,0,3,4'h0));
      vecs.push_back(mk("AUIPC",  AU, 3'd0, 7'h00, 0,0,0, 4,1,1,0,0,0,4'h0));
      vecs.push_back(mk("MUL",    R,  3'd0, 7'h01, 0,0,0, 6,1,1,0,0,0,4'h9));
      vecs.push_back(mk("MULHU",  R,  3'd3, 7'h01, 0,0,0, 6,1,1,0,0,0,4'hA));
      vecs.push_back(mk("DIV",    R,  3'd4, 7'h01, 0,0,0, 35,1,1,0,0,0,4'hB));
      vecs.push_back(mk("REMU",   R,  3'd7, 7'h01, 0,0,0, 35,1,1,0,0,0,4'hC));
      vecs.push_back(mk("OP_7F",  7'h7F, 3'd0, 7'h00, 0,0,0, 3,0,1,1,3,0,4'h0));
      vecs.push_back(mk("SYSTEM", SYS, 3'd0, 7'h00, 0,0,0, 3,0,1,1,3,0,4'h0));
      vecs.push_back(mk("R_F7BAD", R, 3'd0, 7'h21, 0,0,0, 3,0,1,1,3,0,4'h0));

      rst = 1'b1;
      opcode = 7'h00; func3 = 3'd0; func7 = 7'h00;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.busy", int'(busy), 0);
      chk("rst.imem_req", int'(imem_req), 1);
      chk("rst.reg_write", int'(reg_write), 0);
      chk("rst.pc_write", int'(pc_write), 0);
      chk("rst.dmem_req", int'(dmem_req), 0);
      chk("rst.illegal", int'(illegal), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[k]) begin
         run_op(vecs[k].op, vecs[k].f3, vecs[k].f7, vecs[k].z,
                vecs[k].lt, vecs[k].ltu, 0, o);
         chk({vecs[k].nm, ".cycles"}, o.cyc, vecs[k].cyc);
         chk({vecs[k].nm, ".reg_write"}, o.rw, vecs[k].rw);
         chk({vecs[k].nm, ".pc_write"}, o.pw, vecs[k].pw);
         chk({vecs[k].nm, ".illegal"}, o.ill, vecs[k].ill);
         chk({vecs[k].nm, ".pc_src"}, o.pcs, vecs[k].pcs);
         chk({vecs[k].nm, ".result_src"}, o.rs, vecs[k].rs);
         chk({vecs[k].nm, ".alu_control"}, o.alu, vecs[k].alu);
      end

      // Load with dmem_ready arriving on the 4th MEM cycle
      run_op(LD, 3'd2, 7'h00, 0, 0, 0, 3, o);
      chk("LW_slow.cycles", o.cyc, 8);
      chk("LW_slow.dmem_cycles", o.memc, 4);
      chk("LW_slow.mem_write", o.mw, 0);
      chk("LW_slow.result_src", o.rs, 1);
      chk("LW_slow.reg_write", o.rw, 1);

      run_op(ST, 3'd2, 7'h00, 0, 0, 0, 2, o);
      chk("SW_slow.cycles", o.cyc, 6);
      chk("SW_slow.dmem_cycles", o.memc, 3);
      chk("SW_slow.mem_write", o.mw, 3);
      chk("SW_slow.reg_write", o.rw, 0);
      chk("SW_slow.pc_write", o.pw, 1);

      // Same DIV on the M-less instance must trap
      run_op(R, 3'd4, 7'h01, 0, 0, 0, 0, o);
      chk("DIV.cycles", o.cyc, 35);
      chk("DIV_noM.illegal", o.nill, 1);
      chk("DIV_noM.pc_src", o.npcs, 3);
      chk("DIV_noM.reg_write", o.nrw, 0);

      // Reset during the 10th MULDIV cycle of a DIV
      opcode = R; func3 = 3'd4; func7 = 7'h01;
      imem_ready = 1'b1;
      for (int c = 0; c < 11; c++) begin
         @(posedge clk);
         #1 imem_ready = 1'b0;
      end
      @(negedge clk);
      chk("abort.busy_before", int'(busy), 1);
      chk("abort.reg_write_before", int'(reg_write), 0);
      #2 rst = 1'b1;
      #1;
      chk("abort.busy_async", int'(busy), 0);
      chk("abort.imem_req", int'(imem_req), 1);
      chk("abort.reg_write", int'(reg_write), 0);
      chk("abort.pc_write", int'(pc_write), 0);
      @(negedge clk);
      chk("abort.reg_write_held", int'(reg_write), 0);
      chk("abort.pc_write_held", int'(pc_write), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      run_op(R, 3'd0, 7'h00, 0, 0, 0, 0, o);
      chk("post_rst_ADD.cycles", o.cyc, 4);
      chk("post_rst_ADD.reg_write", o.rw, 1);
      chk("post_rst_ADD.alu_control", o.alu, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
